// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS pipeline front end: default widths, reset PC,
// NOP encoding and the Rs/Rt field positions inside an instruction word.
package pipe_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CTRL_W      = 10;
    localparam int unsigned MEMREAD_BIT = 3;
    localparam int unsigned CNT_W       = 16;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;

    typedef logic [4:0] reg_idx_t;

    function automatic reg_idx_t instr_rs(input logic [31:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic reg_idx_t instr_rt(input logic [31:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic W-bit pipeline register: async active-low reset, synchronous clear
// (takes priority) and load enable.
module pipe_reg #(
    parameter int unsigned W       = 32,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = CLR_VAL;
        end else if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_front_stage.sv
// Front-end state of the 5-stage MIPS pipeline: PC, IF/ID and ID/EX control
// registers, plus bubble counter and sticky hazard-protocol error flag.
module pipe_front_stage #(
    parameter int unsigned DATA_W      = pipe_pkg::DATA_W,
    parameter int unsigned CTRL_W      = pipe_pkg::CTRL_W,
    parameter int unsigned MEMREAD_BIT = pipe_pkg::MEMREAD_BIT,
    parameter logic [DATA_W-1:0] RESET_PC = pipe_pkg::RESET_PC[DATA_W-1:0],
    parameter int unsigned CNT_W       = pipe_pkg::CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pc_write_i,
    input  logic              if_id_write_i,
    input  logic              ctrl_bubble_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] pc_next_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] if_id_pc4_o,
    output logic [DATA_W-1:0] if_id_instr_o,
    output logic              if_id_valid_o,
    output logic [CTRL_W-1:0] id_ex_ctrl_o,
    output logic              id_ex_memread_o,
    output logic [4:0]        id_ex_rs_o,
    output logic [4:0]        id_ex_rt_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              protocol_err_o
);
    import pipe_pkg::*;

    logic              pc_en;
    logic [DATA_W-1:0] pc_plus4;
    logic              ctrl_zero;
    logic [4:0]        if_id_rs;
    logic [4:0]        if_id_rt;

    assign pc_en     = flush_i | pc_write_i;
    assign pc_plus4  = pc_o + DATA_W'(4);
    assign ctrl_zero = flush_i | ctrl_bubble_i | ~if_id_valid_o;
    assign if_id_rs  = instr_rs(if_id_instr_o);
    assign if_id_rt  = instr_rt(if_id_instr_o);

    pipe_reg #(.W(DATA_W), .RST_VAL(RESET_PC)) u_pc (
        .clk_i (clk_i),
        .rst_ni(rst_i),
        .en_i  (pc_en),
        .clr_i (1'b0),
        .d_i   (pc_next_i),
        .q_o   (pc_o)
    );

    pipe_reg #(.W(DATA_W), .RST_VAL(NOP_INSTR[DATA_W-1:0]), .CLR_VAL(NOP_INSTR[DATA_W-1:0])) u_if_id_instr (
        .clk_i (clk_i),
        .rst_ni(rst_i),
        .en_i  (if_id_write_i),
        .clr_i (flush_i),
        .d_i   (instr_i),
        .q_o   (if_id_instr_o)
    );

    pipe_reg #(.W(DATA_W)) u_if_id_pc4 (
        .clk_i (clk_i),
        .rst_ni(rst_i),
        .en_i  (if_id_write_i),
        .clr_i (flush_i),
        .d_i   (pc_plus4),
        .q_o   (if_id_pc4_o)
    );

    pipe_reg #(.W(1)) u_if_id_valid (
        .clk_i (clk_i),
        .rst_ni(rst_i),
        .en_i  (if_id_write_i),
        .clr_i (flush_i),
        .d_i   (1'b1),
        .q_o   (if_id_valid_o)
    );

    pipe_reg #(.W(CTRL_W)) u_id_ex_ctrl (
        .clk_i (clk_i),
        .rst_ni(rst_i),
        .en_i  (1'b1),
        .clr_i (ctrl_zero),
        .d_i   (ctrl_i),
        .q_o   (id_ex_ctrl_o)
    );

    // Register fields follow IF/ID every cycle; a bubble carries MemRead=0 so stale indices are harmless.
    pipe_reg #(.W(10)) u_id_ex_regs (
        .clk_i (clk_i),
        .rst_ni(rst_i),
        .en_i  (1'b1),
        .clr_i (1'b0),
        .d_i   ({if_id_rs, if_id_rt}),
        .q_o   ({id_ex_rs_o, id_ex_rt_o})
    );

    assign id_ex_memread_o = id_ex_ctrl_o[MEMREAD_BIT];

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             protocol_err_q;
    logic             protocol_err_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        protocol_err_d = protocol_err_q;
        if (ctrl_bubble_i && !flush_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        // Hazard unit must move PC and IF/ID together and bubble exactly when both hold.
        if ((pc_write_i != if_id_write_i) || (ctrl_bubble_i == pc_write_i)) begin
            protocol_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q    <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign stall_cnt_o    = stall_cnt_q;
    assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_pipe_front_stage.sv
// Directed bench for pipe_front_stage: free run, load-use stall, flush,
// PC+4 wrap, counter saturation, sticky error and asynchronous reset.
module tb_pipe_front_stage;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_i;
    logic        pc_write_i;
    logic        if_id_write_i;
    logic        ctrl_bubble_i;
    logic        flush_i;
    logic        seq_pc;
    logic [31:0] pc_redirect;
    logic [31:0] pc_next_i;
    logic [31:0] instr_i;
    logic [9:0]  ctrl_i;
    logic [31:0] pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic [9:0]  id_ex_ctrl_o;
    logic        id_ex_memread_o;
    logic [4:0]  id_ex_rs_o;
    logic [4:0]  id_ex_rt_o;
    logic [3:0]  stall_cnt_o;
    logic        protocol_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    // lw $2,0($1) at 0, add $3,$2,$4 at 4, filler words elsewhere
    function automatic logic [31:0] imem(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h8C22_0000;
            32'h0000_0004: return 32'h0044_1820;
            default:       return 32'h2000_0000 | {16'h0, addr[15:0]};
        endcase
    endfunction

    function automatic logic [9:0] decode(input logic [31:0] instr);
        if (instr == 32'h0)             return 10'h000;
        else if (instr[31:26] == 6'h23) return 10'h00B;
        else                            return 10'h101;
    endfunction

    assign pc_next_i = seq_pc ? (pc_o + 32'd4) : pc_redirect;
    assign instr_i   = imem(pc_o);
    assign ctrl_i    = decode(if_id_instr_o);

    pipe_front_stage #(.CNT_W(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pc_write_i     (pc_write_i),
        .if_id_write_i  (if_id_write_i),
        .ctrl_bubble_i  (ctrl_bubble_i),
        .flush_i        (flush_i),
        .pc_next_i      (pc_next_i),
        .instr_i        (instr_i),
        .ctrl_i         (ctrl_i),
        .pc_o           (pc_o),
        .if_id_pc4_o    (if_id_pc4_o),
        .if_id_instr_o  (if_id_instr_o),
        .if_id_valid_o  (if_id_valid_o),
        .id_ex_ctrl_o   (id_ex_ctrl_o),
        .id_ex_memread_o(id_ex_memread_o),
        .id_ex_rs_o     (id_ex_rs_o),
        .id_ex_rt_o     (id_ex_rt_o),
        .stall_cnt_o    (stall_cnt_o),
        .protocol_err_o (protocol_err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic iw, input logic bub, input logic fl);
        pc_write_i    = pw;
        if_id_write_i = iw;
        ctrl_bubble_i = bub;
        flush_i       = fl;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pc"},    pc_o, 32'h0);
        check_eq({tag, "_instr"}, if_id_instr_o, 32'h0);
        check_eq({tag, "_pc4"},   if_id_pc4_o, 32'h0);
        check_eq({tag, "_valid"}, 32'(if_id_valid_o), 32'h0);
        check_eq({tag, "_ctrl"},  32'(id_ex_ctrl_o), 32'h0);
        check_eq({tag, "_mrd"},   32'(id_ex_memread_o), 32'h0);
        check_eq({tag, "_rs"},    32'(id_ex_rs_o), 32'h0);
        check_eq({tag, "_rt"},    32'(id_ex_rt_o), 32'h0);
        check_eq({tag, "_cnt"},   32'(stall_cnt_o), 32'h0);
        check_eq({tag, "_err"},   32'(protocol_err_o), 32'h0);
    endtask

    initial begin
        rst_i       = 1'b0;
        seq_pc      = 1'b1;
        pc_redirect = 32'h0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        check_reset_state("rst0");
        rst_i = 1'b1;

        // free run: fetch lw, then add
        tick();
        check_eq("run1_pc",    pc_o, 32'h4);
        check_eq("run1_pc4",   if_id_pc4_o, 32'h4);
        check_eq("run1_valid", 32'(if_id_valid_o), 32'h1);
        check_eq("run1_instr", if_id_instr_o, 32'h8C22_0000);
        check_eq("run1_ctrl",  32'(id_ex_ctrl_o), 32'h0);
        tick();
        check_eq("run2_pc",    pc_o, 32'h8);
        check_eq("run2_pc4",   if_id_pc4_o, 32'h8);
        check_eq("run2_instr", if_id_instr_o, 32'h0044_1820);
        check_eq("run2_ctrl",  32'(id_ex_ctrl_o), 32'h00B);
        check_eq("run2_mrd",   32'(id_ex_memread_o), 32'h1);
        check_eq("run2_rs",    32'(id_ex_rs_o), 32'h1);
        check_eq("run2_rt",    32'(id_ex_rt_o), 32'h2);
        check_eq("run2_ifrs",  32'(if_id_instr_o[25:21]), 32'h2);

        // load-use stall, one cycle
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("stall_pc",    pc_o, 32'h8);
        check_eq("stall_instr", if_id_instr_o, 32'h0044_1820);
        check_eq("stall_pc4",   if_id_pc4_o, 32'h8);
        check_eq("stall_ctrl",  32'(id_ex_ctrl_o), 32'h0);
        check_eq("stall_mrd",   32'(id_ex_memread_o), 32'h0);
        check_eq("stall_cnt",   32'(stall_cnt_o), 32'h1);
        check_eq("stall_rt",    32'(id_ex_rt_o), 32'h4);
        check_eq("stall_err",   32'(protocol_err_o), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("resume_pc",    pc_o, 32'hC);
        check_eq("resume_instr", if_id_instr_o, 32'h2000_0008);
        check_eq("resume_ctrl",  32'(id_ex_ctrl_o), 32'h101);
        check_eq("resume_cnt",   32'(stall_cnt_o), 32'h1);

        // flush overrides pc_write=0 and a concurrent bubble
        seq_pc      = 1'b0;
        pc_redirect = 32'h40;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check_eq("flush_pc",    pc_o, 32'h40);
        check_eq("flush_valid", 32'(if_id_valid_o), 32'h0);
        check_eq("flush_instr", if_id_instr_o, 32'h0);
        check_eq("flush_ctrl",  32'(id_ex_ctrl_o), 32'h0);
        check_eq("flush_cnt",   32'(stall_cnt_o), 32'h1);
        check_eq("flush_err",   32'(protocol_err_o), 32'h0);
        seq_pc = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("postfl_pc",    pc_o, 32'h44);
        check_eq("postfl_valid", 32'(if_id_valid_o), 32'h1);
        check_eq("postfl_instr", if_id_instr_o, 32'h2000_0040);
        check_eq("postfl_ctrl",  32'(id_ex_ctrl_o), 32'h0);

        // PC+4 wraps at the top of the address space
        seq_pc      = 1'b0;
        pc_redirect = 32'hFFFF_FFFC;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("wrap_pc", pc_o, 32'hFFFF_FFFC);
        seq_pc = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("wrap_pc4",   if_id_pc4_o, 32'h0);
        check_eq("wrap_pcnxt", pc_o, 32'h0);
        check_eq("wrap_instr", if_id_instr_o, 32'h2000_FFFC);

        // long bubble: counter reaches 15 after 14 more edges and stays
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) tick();
        check_eq("sat_cnt14", 32'(stall_cnt_o), 32'hE);
        tick();
        check_eq("sat_cnt15", 32'(stall_cnt_o), 32'hF);
        for (int i = 0; i < 7; i++) tick();
        check_eq("sat_hold", 32'(stall_cnt_o), 32'hF);
        check_eq("sat_pc",   pc_o, 32'h0);
        check_eq("sat_err",  32'(protocol_err_o), 32'h0);

        // inconsistent hazard controls set the sticky error
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("err_set", 32'(protocol_err_o), 32'h1);
        check_eq("err_pc",  pc_o, 32'h4);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        check_eq("err_sticky", 32'(protocol_err_o), 32'h1);
        check_eq("err_cnt",    32'(stall_cnt_o), 32'hF);

        // asynchronous reset between edges, mid-stall
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        #2;
        rst_i = 1'b0;
        #1;
        check_reset_state("arst");
        tick();
        check_eq("arst_hold_pc", pc_o, 32'h0);
        check_eq("arst_hold_cnt", 32'(stall_cnt_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
